fp_wb_collector: RTL and testbench

Writeback collector for the FP execute units: fadd/sub, fmul and fdiv/sqrt. Each pipelined unit presents a result with `p_result`, a 32-bit value and its `exe_p_mux_bus_type` bundle. This block grants one result per cycle to the single FP writeback path using a round-robin order. It holds back the losing units by deasserting their per-unit `en`, and it registers the granted result toward the EXE/MEM mux.

---
 rtl/fp_wb_collector_pkg.sv | 19 +
 rtl/fp_wb_collector_rr_arbiter.sv | 35 +++
 rtl/fp_wb_collector.sv | 131 +++++++++++++
 tb/tb_fp_wb_collector.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_wb_collector_pkg.sv
// Shared types and constants for the FP writeback collector.
//   exe_p_mux_bus_type : pipeline bundle travelling with each FP result
//   FP_WB_UNITS        : number of FP units feeding the writeback path
//   FP_UNIT_*          : unit index constants (position in the request vector)
package fp_wb_collector_pkg;

  localparam int unsigned FP_WB_UNITS    = 3;
  localparam int unsigned FP_UNIT_ADDSUB = 0;
  localparam int unsigned FP_UNIT_MUL    = 1;
  localparam int unsigned FP_UNIT_DIV    = 2;

  typedef struct packed {
    logic [4:0] rd_addr;
    logic       rd_we;
    logic [4:0] fflags;
    logic [2:0] rob_tag;
  } exe_p_mux_bus_type;

endpackage

// File: rtl/fp_wb_collector_rr_arbiter.sv
// Combinational N-way round-robin arbiter.
//   req_i   : request vector
//   ptr_i   : index where the search starts (must be < N)
//   grant_o : one-hot grant, zero when nothing requests
//   idx_o   : encoded index of the granted requester (0 when no grant)
module fp_wb_collector_rr_arbiter #(
  parameter int unsigned N    = 3,
  parameter int unsigned IdxW = 2
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [N-1:0]    grant_o,
  output logic [IdxW-1:0] idx_o
);

  always_comb begin
    int unsigned cand;
    logic        found;
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = 0;
    for (int unsigned k = 0; k < N; k++) begin
      // Walk from the pointer, wrapping modulo N.
      cand = 32'(ptr_i) + k;
      if (cand >= N) cand = cand - N;
      if (!found && req_i[cand[IdxW-1:0]]) begin
        found                      = 1'b1;
        grant_o[cand[IdxW-1:0]]    = 1'b1;
        idx_o                      = cand[IdxW-1:0];
      end
    end
  end

endmodule

// File: rtl/fp_wb_collector.sv
// FP writeback collector: grants one FP unit result per cycle (round-robin)
// onto the single writeback path and registers it toward the EXE/MEM mux.
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   en_i            : global pipeline enable (low = core stalled)
//   flush_i         : kill the writeback register this cycle
//   unit_valid_i    : per-unit result valid (p_result)
//   unit_result_i   : per-unit results, unit i at [i*DATA_W +: DATA_W]
//   unit_bus_i      : per-unit pipeline bundles
//   unit_en_o       : per-unit enable, low freezes a unit that lost arbitration
//   wb_valid_o, wb_result_o, wb_bus_o, wb_unit_o : registered granted result
//   stall_cnt_o     : saturating count of unit-cycles lost to arbitration
module fp_wb_collector
  import fp_wb_collector_pkg::*;
#(
  parameter int unsigned NUM_UNITS = FP_WB_UNITS,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned CNT_W     = 16,
  localparam int unsigned IdxW     = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          en_i,
  input  logic                          flush_i,
  input  logic [NUM_UNITS-1:0]          unit_valid_i,
  input  logic [NUM_UNITS*DATA_W-1:0]   unit_result_i,
  input  exe_p_mux_bus_type [NUM_UNITS-1:0] unit_bus_i,
  output logic [NUM_UNITS-1:0]          unit_en_o,
  output logic                          wb_valid_o,
  output logic [DATA_W-1:0]             wb_result_o,
  output exe_p_mux_bus_type             wb_bus_o,
  output logic [IdxW-1:0]               wb_unit_o,
  output logic [CNT_W-1:0]              stall_cnt_o
);

  localparam int unsigned PopW = $clog2(NUM_UNITS + 1);
  localparam int unsigned SumW = CNT_W + PopW;
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [NUM_UNITS-1:0] req, grant, lost;
  logic [IdxW-1:0]      gidx;
  logic                 any_grant;

  logic              wb_valid_q, wb_valid_d;
  logic [DATA_W-1:0] wb_result_q, wb_result_d;
  exe_p_mux_bus_type wb_bus_q, wb_bus_d;
  logic [IdxW-1:0]   wb_unit_q, wb_unit_d;
  logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  // Requests are only arbitrated while the pipeline moves and nothing is flushed.
  assign req = (en_i && !flush_i) ? unit_valid_i : '0;

  fp_wb_collector_rr_arbiter #(
    .N    (NUM_UNITS),
    .IdxW (IdxW)
  ) u_rr_arbiter (
    .req_i   (req),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant),
    .idx_o   (gidx)
  );

  assign any_grant = |grant;
  assign lost      = req & ~grant;
  // During flush req is zero, so every unit simply follows en_i.
  assign unit_en_o = {NUM_UNITS{en_i}} & ~lost;

  always_comb begin
    wb_valid_d  = wb_valid_q;
    wb_result_d = wb_result_q;
    wb_bus_d    = wb_bus_q;
    wb_unit_d   = wb_unit_q;
    if (flush_i) begin
      wb_valid_d = 1'b0;
      wb_bus_d   = '0;
    end else if (en_i) begin
      if (any_grant) begin
        wb_valid_d  = 1'b1;
        wb_result_d = unit_result_i[gidx*DATA_W +: DATA_W];
        wb_bus_d    = unit_bus_i[gidx];
        wb_unit_d   = gidx;
      end else begin
        wb_valid_d = 1'b0;
        wb_bus_d   = '0;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (any_grant) begin
      rr_ptr_d = (gidx == IdxW'(NUM_UNITS - 1)) ? '0 : gidx + IdxW'(1);
    end
  end

  always_comb begin
    logic [SumW-1:0] pop;
    logic [SumW-1:0] sum;
    pop = '0;
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      pop = pop + SumW'(lost[i]);
    end
    sum         = SumW'(stall_cnt_q) + pop;
    stall_cnt_d = (sum > SumW'(CntMax)) ? CntMax : sum[CNT_W-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wb_valid_q  <= 1'b0;
      wb_result_q <= '0;
      wb_bus_q    <= '0;
      wb_unit_q   <= '0;
      rr_ptr_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      wb_valid_q  <= wb_valid_d;
      wb_result_q <= wb_result_d;
      wb_bus_q    <= wb_bus_d;
      wb_unit_q   <= wb_unit_d;
      rr_ptr_q    <= rr_ptr_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign wb_valid_o  = wb_valid_q;
  assign wb_result_o = wb_result_q;
  assign wb_bus_o    = wb_bus_q;
  assign wb_unit_o   = wb_unit_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_fp_wb_collector.sv
// Self-checking bench for fp_wb_collector: directed scenarios followed by
// randomized traffic, compared against a cycle-level reference model.
module tb_fp_wb_collector;
  import fp_wb_collector_pkg::*;

  localparam int NU     = 3;
  localparam int DW     = 32;
  localparam int CW     = 4;
  localparam int CNTMAX = (1 << CW) - 1;
  localparam int BUSW   = $bits(exe_p_mux_bus_type);

  logic                    clk_i = 1'b0;
  logic                    rst_ni;
  logic                    en_i;
  logic                    flush_i;
  logic [NU-1:0]           unit_valid_i;
  logic [NU*DW-1:0]        unit_result_i;
  exe_p_mux_bus_type [NU-1:0] unit_bus_i;
  logic [NU-1:0]           unit_en_o;
  logic                    wb_valid_o;
  logic [DW-1:0]           wb_result_o;
  exe_p_mux_bus_type       wb_bus_o;
  logic [1:0]              wb_unit_o;
  logic [CW-1:0]           stall_cnt_o;

  fp_wb_collector #(
    .NUM_UNITS (NU),
    .DATA_W    (DW),
    .CNT_W     (CW)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .en_i          (en_i),
    .flush_i       (flush_i),
    .unit_valid_i  (unit_valid_i),
    .unit_result_i (unit_result_i),
    .unit_bus_i    (unit_bus_i),
    .unit_en_o     (unit_en_o),
    .wb_valid_o    (wb_valid_o),
    .wb_result_o   (wb_result_o),
    .wb_bus_o      (wb_bus_o),
    .wb_unit_o     (wb_unit_o),
    .stall_cnt_o   (stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model state.
  int                m_ptr, m_stall, m_wb_unit;
  logic              m_wb_valid;
  logic [DW-1:0]     m_wb_result;
  exe_p_mux_bus_type m_wb_bus;

  // Behavioural FP units: a pending result per unit, held while frozen.
  logic              u_valid [NU];
  logic [DW-1:0]     u_res   [NU];
  exe_p_mux_bus_type u_bus   [NU];
  int                refill_mode;  // 0: drop after advance, 1: random, 2: always request

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int model_grant(input logic [NU-1:0] req, input int ptr);
    for (int k = 0; k < NU; k++) begin
      if (req[(ptr + k) % NU]) return (ptr + k) % NU;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr       = 0;
    m_stall     = 0;
    m_wb_valid  = 1'b0;
    m_wb_result = '0;
    m_wb_bus    = '0;
    m_wb_unit   = 0;
  endtask

  task automatic new_result(input int i);
    logic [31:0] r;
    r        = $urandom;
    u_res[i] = $urandom;
    u_bus[i] = r[BUSW-1:0];
  endtask

  // One clock cycle: entered and left on a falling edge.
  task automatic step(input logic en, input logic flush, output logic [NU-1:0] uen_seen);
    logic [NU-1:0] req, exp_uen;
    int g, lost;
    en_i    = en;
    flush_i = flush;
    for (int i = 0; i < NU; i++) begin
      unit_valid_i[i]           = u_valid[i];
      unit_result_i[i*DW +: DW] = u_res[i];
      unit_bus_i[i]             = u_bus[i];
    end
    req = (en && !flush) ? unit_valid_i : '0;
    g   = model_grant(req, m_ptr);
    for (int i = 0; i < NU; i++) exp_uen[i] = en && !(req[i] && g != i);
    #1;
    uen_seen = unit_en_o;
    check_eq("unit_en", 64'(unit_en_o), 64'(exp_uen));
    @(posedge clk_i);
    if (flush) begin
      m_wb_valid = 1'b0;
      m_wb_bus   = '0;
    end else if (en) begin
      if (g >= 0) begin
        m_wb_valid  = 1'b1;
        m_wb_result = u_res[g];
        m_wb_bus    = u_bus[g];
        m_wb_unit   = g;
        m_ptr       = (g + 1) % NU;
      end else begin
        m_wb_valid = 1'b0;
        m_wb_bus   = '0;
      end
    end
    lost    = $countones(req) - ((g >= 0) ? 1 : 0);
    m_stall = (m_stall + lost > CNTMAX) ? CNTMAX : m_stall + lost;
    // Units sample their enable at this edge.
    for (int i = 0; i < NU; i++) begin
      if (exp_uen[i]) begin
        case (refill_mode)
          0: u_valid[i] = 1'b0;
          1: begin u_valid[i] = 1'($urandom_range(0, 1)); new_result(i); end
          default: begin u_valid[i] = 1'b1; new_result(i); end
        endcase
      end
    end
    @(negedge clk_i);
    check_eq("wb_valid",  64'(wb_valid_o),  64'(m_wb_valid));
    check_eq("wb_result", 64'(wb_result_o), 64'(m_wb_result));
    check_eq("wb_bus",    64'(wb_bus_o),    64'(m_wb_bus));
    check_eq("wb_unit",   64'(wb_unit_o),   64'(m_wb_unit));
    check_eq("stall_cnt", 64'(stall_cnt_o), 64'(m_stall));
  endtask

  // Asynchronous reset asserted mid-cycle, released on a falling edge.
  task automatic do_reset();
    #2 rst_ni = 1'b0;
    #1;
    check_eq("rst_wb_valid",  64'(wb_valid_o),  64'(0));
    check_eq("rst_wb_result", 64'(wb_result_o), 64'(0));
    check_eq("rst_stall_cnt", 64'(stall_cnt_o), 64'(0));
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [NU-1:0] uen;
    rst_ni        = 1'b0;
    en_i          = 1'b1;
    flush_i       = 1'b0;
    unit_valid_i  = '0;
    unit_result_i = '0;
    unit_bus_i    = '0;
    refill_mode   = 0;
    for (int i = 0; i < NU; i++) begin
      u_valid[i] = 1'b0;
      u_res[i]   = '0;
      u_bus[i]   = '0;
    end
    model_reset();

    // Reset state.
    @(negedge clk_i);
    @(negedge clk_i);
    check_eq("reset_unit_en",   64'(unit_en_o),   64'(3'b111));
    check_eq("reset_wb_valid",  64'(wb_valid_o),  64'(0));
    check_eq("reset_stall_cnt", 64'(stall_cnt_o), 64'(0));
    rst_ni = 1'b1;

    // Single request from fadd/sub.
    u_valid[0] = 1'b1;
    u_res[0]   = 32'h3FC0_0000;
    u_bus[0]   = 14'h1A5;
    step(1'b1, 1'b0, uen);
    check_eq("single_valid",  64'(wb_valid_o),  64'(1));
    check_eq("single_result", 64'(wb_result_o), 64'(32'h3FC0_0000));
    check_eq("single_unit",   64'(wb_unit_o),   64'(0));

    // Three-way collision from pointer 0.
    do_reset();
    for (int i = 0; i < NU; i++) begin
      u_valid[i] = 1'b1;
      new_result(i);
    end
    step(1'b1, 1'b0, uen);
    check_eq("coll_en0", 64'(uen), 64'(3'b001));
    check_eq("coll_g0",  64'(wb_unit_o), 64'(0));
    step(1'b1, 1'b0, uen);
    check_eq("coll_en1", 64'(uen), 64'(3'b011));
    check_eq("coll_g1",  64'(wb_unit_o), 64'(1));
    step(1'b1, 1'b0, uen);
    check_eq("coll_en2", 64'(uen), 64'(3'b111));
    check_eq("coll_g2",  64'(wb_unit_o), 64'(2));
    check_eq("coll_stall", 64'(stall_cnt_o), 64'(3));

    // Wrap-around: move pointer to 2, then request units 0 and 2.
    u_valid[1] = 1'b1;
    new_result(1);
    step(1'b1, 1'b0, uen);
    u_valid[0] = 1'b1;
    u_valid[2] = 1'b1;
    new_result(0);
    new_result(2);
    step(1'b1, 1'b0, uen);
    check_eq("wrap_first",  64'(wb_unit_o), 64'(2));
    step(1'b1, 1'b0, uen);
    check_eq("wrap_second", 64'(wb_unit_o), 64'(0));

    // Stall for two cycles, then flush with unit 1 requesting.
    u_valid[1] = 1'b1;
    new_result(1);
    for (int c = 0; c < 2; c++) begin
      step(1'b0, 1'b0, uen);
      check_eq("stall_unit_en",  64'(uen),        64'(3'b000));
      check_eq("stall_wb_valid", 64'(wb_valid_o), 64'(1));
      check_eq("stall_wb_unit",  64'(wb_unit_o),  64'(0));
    end
    step(1'b1, 1'b1, uen);
    check_eq("flush_unit_en",  64'(uen),        64'(3'b111));
    check_eq("flush_wb_valid", 64'(wb_valid_o), 64'(0));
    // Pointer must still be 1 after the flush.
    for (int i = 0; i < NU; i++) begin
      u_valid[i] = 1'b1;
      new_result(i);
    end
    step(1'b1, 1'b0, uen);
    check_eq("post_flush_grant", 64'(wb_unit_o), 64'(1));

    // Saturation with a sustained collision.
    do_reset();
    refill_mode = 2;
    for (int i = 0; i < NU; i++) begin
      u_valid[i] = 1'b1;
      new_result(i);
    end
    for (int c = 0; c < 12; c++) step(1'b1, 1'b0, uen);
    check_eq("sat_stall", 64'(stall_cnt_o), 64'(CNTMAX));

    // Randomized traffic with occasional stalls, flushes and resets.
    do_reset();
    refill_mode = 1;
    for (int c = 0; c < 600; c++) begin
      logic en, fl;
      en = ($urandom_range(0, 99) < 85);
      fl = ($urandom_range(0, 99) < 8);
      step(en, fl, uen);
      if ($urandom_range(0, 199) == 0) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
